// File: rtl/mem_strobe_pkg.sv
// Shared types and defaults for the strobe-bus slave.
// Optional drop counter enabled by MEM_STROBE_SLV_DROPCNT_EN (see mem_strobe_slv).
package mem_strobe_pkg;

  localparam int AW_DEF    = 16;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {ACC_NONE, ACC_RD, ACC_WR} acc_kind_e;

  // Command layout at default widths; the top re-declares it with its own AW/DW.
  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } cmd_t;

  function automatic acc_kind_e decode_acc(input logic start, input logic web, input logic oeb);
    if (!start)    return ACC_NONE;
    if (!web)      return ACC_WR;
    if (!oeb)      return ACC_RD;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/mem_strobe_fifo.sv
// Command FIFO: DEPTH entries, head presented combinationally, push accepted
// when full only if a pop happens on the same edge.
module mem_strobe_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         empty_nxt
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr, count, count_nxt;
  logic         push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr[PW-1:0]];

  assign count     = wr_ptr - rd_ptr;
  assign count_nxt = count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
  assign empty_nxt = (count_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_strobe_slv.sv
// Strobe-bus slave: edge-detects a select, queues commands to a ready/valid
// backend and returns in-order read data. Define MEM_STROBE_SLV_DROPCNT_EN for drop_cnt.
import mem_strobe_pkg::*;

module mem_strobe_slv #(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] idata,
  input  logic          ce,
  input  logic          csb,
  input  logic          web,
  input  logic          oeb,
  output logic [DW-1:0] odata,
  output logic          req_valid,
  output logic          req_we,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] req_wdata,
  input  logic          req_ready,
  input  logic          rsp_valid,
  input  logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          ovf
`ifdef MEM_STROBE_SLV_DROPCNT_EN
  ,output logic [7:0]   drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } slv_cmd_t;

  logic      sel, sel_q, start;
  acc_kind_e acc;
  slv_cmd_t  push_cmd, head;
  logic      push, pop, full, empty, empty_nxt, drop;
  logic      rd_pop, rsp_ok;
  logic [CW-1:0] rd_cnt, rd_cnt_nxt;

  assign sel   = ce & ~csb;
  assign start = sel & ~sel_q;
  assign acc   = decode_acc(start, web, oeb);
  assign push  = (acc != ACC_NONE);

  always_comb begin
    push_cmd.we    = (acc == ACC_WR);
    push_cmd.addr  = addr;
    push_cmd.wdata = (acc == ACC_WR) ? idata : '0;
  end

  mem_strobe_fifo #(.DEPTH(DEPTH), .W($bits(slv_cmd_t))) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .din       (push_cmd),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .empty_nxt (empty_nxt)
  );

  assign req_valid = ~empty;
  assign req_we    = head.we;
  assign req_addr  = head.addr;
  assign req_wdata = head.wdata;
  assign pop       = req_valid & req_ready;
  assign drop      = push & full & ~pop;

  // A response with nothing outstanding is stray (e.g. after reset) and ignored.
  assign rd_pop = pop & ~head.we;
  assign rsp_ok = rsp_valid & (rd_cnt != '0);

  always_comb begin
    rd_cnt_nxt = rd_cnt;
    case ({rd_pop, rsp_ok})
      2'b10:   rd_cnt_nxt = rd_cnt + CW'(1);
      2'b01:   rd_cnt_nxt = rd_cnt - CW'(1);
      default: rd_cnt_nxt = rd_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 1'b0;
      rd_cnt <= '0;
      odata  <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      sel_q  <= sel;
      rd_cnt <= rd_cnt_nxt;
      busy   <= ~empty_nxt | (rd_cnt_nxt != '0);
      if (rsp_ok) odata <= rsp_rdata;
      if (drop)   ovf   <= 1'b1;
    end
  end

`ifdef MEM_STROBE_SLV_DROPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule
